// File: rtl/dmem_responder.sv
// Memory-side responder for the datapath load/store port: req/ack handshake with
// configurable wait states, byte/half/word RAM access and two memory-mapped registers.
module dmem_responder #(
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned WAIT      = 1,
    parameter logic [31:0] MMIO_BASE = 32'hF000_0000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        ack_o,
    output logic        fault_o,
    output logic [31:0] rdata_o,
    output logic [31:0] led_out_o
);

    localparam int unsigned DEPTH     = 1 << ADDR_W;
    localparam bit          NO_WAIT   = (WAIT == 0);
    localparam logic [2:0]  WAIT_INIT = NO_WAIT ? 3'd0 : 3'(WAIT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_e;

    state_e      state_q;
    logic [2:0]  waitCnt_q;
    logic        we_q;
    logic [2:0]  funct3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        ack_q;
    logic        fault_q;
    logic [31:0] rdata_q;
    logic [31:0] led_q;
    logic [31:0] cycle_q;

    logic [31:0] mem [DEPTH];

    logic              curWe;
    logic [2:0]        curFunct3;
    logic [31:0]       curAddr;
    logic [31:0]       curWdata;
    logic              isByte;
    logic              isHalf;
    logic              isWord;
    logic              legalF3;
    logic              misaligned;
    logic              hitCnt;
    logic              hitLed;
    logic              hitMmio;
    logic              hitRam;
    logic              reqFault;
    logic [ADDR_W-1:0] wordIdx;
    logic [31:0]       ramWord;
    logic [7:0]        byteVal;
    logic [15:0]       halfVal;
    logic [31:0]       loadData;
    logic [31:0]       respData;
    logic [3:0]        byteEn;
    logic [31:0]       wdataLanes;
    logic              enterResp;
    logic              commitRam;
    logic              commitLed;

    // With no wait states the response is formed in the same cycle the request
    // arrives, so decode looks at the live inputs in IDLE and the latched copy later.
    always_comb begin
        if (state_q == S_IDLE) begin
            curWe     = we_i;
            curFunct3 = funct3_i;
            curAddr   = addr_i;
            curWdata  = wdata_i;
        end else begin
            curWe     = we_q;
            curFunct3 = funct3_q;
            curAddr   = addr_q;
            curWdata  = wdata_q;
        end
    end

    always_comb begin
        isByte     = (curFunct3[1:0] == 2'b00);
        isHalf     = (curFunct3[1:0] == 2'b01);
        isWord     = (curFunct3[1:0] == 2'b10);
        legalF3    = curWe ? (curFunct3 inside {3'b000, 3'b001, 3'b010})
                           : (curFunct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        misaligned = (isHalf && curAddr[0]) || (isWord && (curAddr[1:0] != 2'b00));
        hitCnt     = (curAddr == MMIO_BASE);
        hitLed     = (curAddr == (MMIO_BASE + 32'd4));
        hitMmio    = hitCnt || hitLed;
        hitRam     = (curAddr[31:ADDR_W+2] == '0) && !hitMmio;
        reqFault   = !legalF3 || misaligned || !(hitRam || hitMmio) || (hitMmio && !isWord);
    end

    always_comb begin
        wordIdx = curAddr[ADDR_W+1:2];
        ramWord = mem[wordIdx];
        byteVal = ramWord[{curAddr[1:0], 3'b000} +: 8];
        halfVal = ramWord[{curAddr[1], 4'b0000} +: 16];
        case (curFunct3)
            3'b000:  loadData = {{24{byteVal[7]}}, byteVal};
            3'b001:  loadData = {{16{halfVal[15]}}, halfVal};
            3'b010:  loadData = ramWord;
            3'b100:  loadData = {24'd0, byteVal};
            3'b101:  loadData = {16'd0, halfVal};
            default: loadData = '0;
        endcase
        if (reqFault || curWe) begin
            respData = '0;
        end else if (hitCnt) begin
            respData = cycle_q;
        end else if (hitLed) begin
            respData = led_q;
        end else begin
            respData = loadData;
        end
    end

    always_comb begin
        if (isByte) begin
            byteEn     = 4'b0001 << curAddr[1:0];
            wdataLanes = {4{curWdata[7:0]}};
        end else if (isHalf) begin
            byteEn     = curAddr[1] ? 4'b1100 : 4'b0011;
            wdataLanes = {2{curWdata[15:0]}};
        end else begin
            byteEn     = 4'b1111;
            wdataLanes = curWdata;
        end
        enterResp = ((state_q == S_IDLE) && req_i && NO_WAIT)
                 || ((state_q == S_WAIT) && (waitCnt_q == 3'd0));
        commitRam = enterResp && curWe && !reqFault && hitRam;
        commitLed = enterResp && curWe && !reqFault && hitLed;
    end

    // RAM has no reset; the reset gate keeps a pending store from landing while reset is held.
    always_ff @(posedge clk_i) begin
        if (rst_ni && commitRam) begin
            for (int i = 0; i < 4; i++) begin
                if (byteEn[i]) begin
                    mem[wordIdx][8*i +: 8] <= wdataLanes[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            waitCnt_q <= 3'd0;
            we_q      <= 1'b0;
            funct3_q  <= 3'd0;
            addr_q    <= '0;
            wdata_q   <= '0;
            ack_q     <= 1'b0;
            fault_q   <= 1'b0;
            rdata_q   <= '0;
            led_q     <= '0;
            cycle_q   <= '0;
        end else begin
            cycle_q <= cycle_q + 32'd1;
            ack_q   <= 1'b0;
            if (commitLed) begin
                led_q <= curWdata;
            end
            if (enterResp) begin
                ack_q   <= 1'b1;
                fault_q <= reqFault;
                rdata_q <= respData;
            end
            case (state_q)
                S_IDLE: begin
                    if (req_i) begin
                        we_q     <= we_i;
                        funct3_q <= funct3_i;
                        addr_q   <= addr_i;
                        wdata_q  <= wdata_i;
                        if (NO_WAIT) begin
                            state_q <= S_RESP;
                        end else begin
                            waitCnt_q <= WAIT_INIT;
                            state_q   <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (waitCnt_q == 3'd0) begin
                        state_q <= S_RESP;
                    end else begin
                        waitCnt_q <= waitCnt_q - 3'd1;
                    end
                end
                S_RESP:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign ack_o     = ack_q;
    assign fault_o   = fault_q;
    assign rdata_o   = rdata_q;
    assign led_out_o = led_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder: main checks on a WAIT=1 instance,
// back-to-back timing on WAIT=0 and latency on WAIT=7.
module tb_dmem_responder;

    localparam logic [31:0] MB = 32'hF000_0000;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    logic        reqA, weA, ackA, faultA;
    logic [2:0]  f3A;
    logic [31:0] addrA, wdA, rdataA, ledA;
    logic        reqZ, weZ, ackZ, faultZ;
    logic [2:0]  f3Z;
    logic [31:0] addrZ, wdZ, rdataZ, ledZ;
    logic        reqS, weS, ackS, faultS;
    logic [2:0]  f3S;
    logic [31:0] addrS, wdS, rdataS, ledS;

    always #5 clk = ~clk;

    dmem_responder #(.ADDR_W(10), .WAIT(1), .MMIO_BASE(MB)) dutA (
        .clk_i(clk), .rst_ni(rst_n), .req_i(reqA), .we_i(weA), .funct3_i(f3A),
        .addr_i(addrA), .wdata_i(wdA), .ack_o(ackA), .fault_o(faultA),
        .rdata_o(rdataA), .led_out_o(ledA));

    dmem_responder #(.ADDR_W(10), .WAIT(0), .MMIO_BASE(MB)) dutZ (
        .clk_i(clk), .rst_ni(rst_n), .req_i(reqZ), .we_i(weZ), .funct3_i(f3Z),
        .addr_i(addrZ), .wdata_i(wdZ), .ack_o(ackZ), .fault_o(faultZ),
        .rdata_o(rdataZ), .led_out_o(ledZ));

    dmem_responder #(.ADDR_W(10), .WAIT(7), .MMIO_BASE(MB)) dutS (
        .clk_i(clk), .rst_ni(rst_n), .req_i(reqS), .we_i(weS), .funct3_i(f3S),
        .addr_i(addrS), .wdata_i(wdS), .ack_o(ackS), .fault_o(faultS),
        .rdata_o(rdataS), .led_out_o(ledS));

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // One access on the WAIT=1 instance: checks latency, fault, rdata and the single-cycle ack,
    // then returns in the IDLE cycle following the response.
    task automatic applyStimulus(input string tag, input logic w, input logic [2:0] f3,
                                 input logic [31:0] a, input logic [31:0] d,
                                 input logic [31:0] expRd, input logic expFault,
                                 output logic [31:0] rd);
        int lat;
        reqA = 1'b1; weA = w; f3A = f3; addrA = a; wdA = d;
        @(posedge clk); #1;
        reqA = 1'b0;
        lat = 1;
        while (!ackA && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        rd = rdataA;
        checkOutput({tag, "_lat"}, 32'(lat), 32'd2);
        checkOutput({tag, "_fault"}, {31'd0, faultA}, {31'd0, expFault});
        checkOutput({tag, "_rdata"}, rdataA, expRd);
        @(posedge clk); #1;
        checkOutput({tag, "_ackPulse"}, {31'd0, ackA}, 32'd0);
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] cnt1;
        int          lat;

        rst_n = 1'b0;
        reqA = 0; weA = 0; f3A = 0; addrA = 0; wdA = 0;
        reqZ = 0; weZ = 0; f3Z = 0; addrZ = 0; wdZ = 0;
        reqS = 0; weS = 0; f3S = 0; addrS = 0; wdS = 0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rstAck", {31'd0, ackA}, 32'd0);
        checkOutput("rstFault", {31'd0, faultA}, 32'd0);
        checkOutput("rstRdata", rdataA, 32'd0);
        checkOutput("rstLed", ledA, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        $display("[TB] reset released");

        applyStimulus("sw10", 1'b1, 3'b010, 32'h10, 32'h8000_00FF, 32'h0, 1'b0, rd);
        applyStimulus("lw10", 1'b0, 3'b010, 32'h10, 32'h0, 32'h8000_00FF, 1'b0, rd);
        applyStimulus("sb13", 1'b1, 3'b000, 32'h13, 32'h1234_56AB, 32'h0, 1'b0, rd);
        applyStimulus("lb13", 1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFF_FFAB, 1'b0, rd);
        applyStimulus("lbu13", 1'b0, 3'b100, 32'h13, 32'h0, 32'h0000_00AB, 1'b0, rd);
        applyStimulus("lw10b", 1'b0, 3'b010, 32'h10, 32'h0, 32'hAB00_00FF, 1'b0, rd);

        applyStimulus("lhMis", 1'b0, 3'b001, 32'h11, 32'h0, 32'h0, 1'b1, rd);
        applyStimulus("swMis", 1'b1, 3'b010, 32'h12, 32'hDEAD_BEEF, 32'h0, 1'b1, rd);
        applyStimulus("lwRange", 1'b0, 3'b010, 32'h1000, 32'h0, 32'h0, 1'b1, rd);
        applyStimulus("f3bad", 1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1, rd);
        applyStimulus("sbF3bad", 1'b1, 3'b100, 32'h10, 32'h0000_0077, 32'h0, 1'b1, rd);
        applyStimulus("lw10c", 1'b0, 3'b010, 32'h10, 32'h0, 32'hAB00_00FF, 1'b0, rd);

        applyStimulus("lh12", 1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFF_AB00, 1'b0, rd);
        applyStimulus("lhu12", 1'b0, 3'b101, 32'h12, 32'h0, 32'h0000_AB00, 1'b0, rd);
        applyStimulus("sh10", 1'b1, 3'b001, 32'h10, 32'h9999_1234, 32'h0, 1'b0, rd);
        applyStimulus("lw10d", 1'b0, 3'b010, 32'h10, 32'h0, 32'hAB00_1234, 1'b0, rd);

        applyStimulus("sbLast", 1'b1, 3'b000, 32'hFFF, 32'h0000_005C, 32'h0, 1'b0, rd);
        applyStimulus("lbLast", 1'b0, 3'b000, 32'hFFF, 32'h0, 32'h0000_005C, 1'b0, rd);
        applyStimulus("sbPast", 1'b1, 3'b000, 32'h1000, 32'h0000_0011, 32'h0, 1'b1, rd);

        applyStimulus("swLed", 1'b1, 3'b010, MB + 32'd4, 32'h5A5A_5A5A, 32'h0, 1'b0, rd);
        checkOutput("ledOut", ledA, 32'h5A5A_5A5A);
        applyStimulus("lwLed", 1'b0, 3'b010, MB + 32'd4, 32'h0, 32'h5A5A_5A5A, 1'b0, rd);
        applyStimulus("sbLed", 1'b1, 3'b000, MB + 32'd4, 32'h0000_0011, 32'h0, 1'b1, rd);
        checkOutput("ledKeep", ledA, 32'h5A5A_5A5A);
        applyStimulus("swCnt", 1'b1, 3'b010, MB, 32'h1234_5678, 32'h0, 1'b0, rd);
        applyStimulus("lhCnt", 1'b0, 3'b001, MB, 32'h0, 32'h0, 1'b1, rd);

        // Two counter reads whose requests start exactly 10 cycles apart.
        reqA = 1'b1; weA = 1'b0; f3A = 3'b010; addrA = MB;
        @(posedge clk); #1;
        reqA = 1'b0;
        @(posedge clk); #1;
        checkOutput("cnt1Ack", {31'd0, ackA}, 32'd1);
        cnt1 = rdataA;
        repeat (8) @(posedge clk);
        #1;
        reqA = 1'b1;
        @(posedge clk); #1;
        reqA = 1'b0;
        @(posedge clk); #1;
        checkOutput("cnt2Ack", {31'd0, ackA}, 32'd1);
        checkOutput("cntDelta", rdataA - cnt1, 32'd10);
        @(posedge clk); #1;

        applyStimulus("sw20", 1'b1, 3'b010, 32'h20, 32'h1111_2222, 32'h0, 1'b0, rd);
        reqA = 1'b1; weA = 1'b1; f3A = 3'b010; addrA = 32'h20; wdA = 32'h1234_5678;
        @(posedge clk); #1;
        reqA = 1'b0;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checkOutput("rstMidAck", {31'd0, ackA}, 32'd0);
        end
        checkOutput("rstMidLed", ledA, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        applyStimulus("lw20", 1'b0, 3'b010, 32'h20, 32'h0, 32'h1111_2222, 1'b0, rd);

        // WAIT=0 with req held high: a new request every other cycle.
        reqZ = 1'b1; weZ = 1'b1; f3Z = 3'b010; addrZ = 32'h4; wdZ = 32'hCAFE_F00D;
        for (int n = 1; n <= 8; n++) begin
            @(posedge clk); #1;
            checkOutput("b2bAck", {31'd0, ackZ}, 32'(n % 2));
        end
        reqZ = 1'b0;
        @(posedge clk); #1;
        reqZ = 1'b1; weZ = 1'b0;
        @(posedge clk); #1;
        reqZ = 1'b0;
        checkOutput("z_ack", {31'd0, ackZ}, 32'd1);
        checkOutput("z_rdata", rdataZ, 32'hCAFE_F00D);
        checkOutput("z_fault", {31'd0, faultZ}, 32'd0);

        reqS = 1'b1; weS = 1'b0; f3S = 3'b010; addrS = MB + 32'd4;
        @(posedge clk); #1;
        reqS = 1'b0;
        lat = 1;
        while (!ackS && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        checkOutput("s_lat", 32'(lat), 32'd8);
        checkOutput("s_rdata", rdataS, 32'd0);
        checkOutput("s_fault", {31'd0, faultS}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Memory-side responder for the single-cycle datapath's load/store port. It accepts one request at a time over a req/ack handshake, with a configurable number of wait states. It serves word-addressed RAM with byte, half and word access, sign or zero extension on loads, and misalignment/decode faults. It also provides two memory-mapped registers: a free-running cycle counter and an LED register. It sits between the datapath's ALU_out/Data_out/Data_in signals and the board I/O.

## Interface
- ADDR_W, 10: RAM word-address bits. RAM is 2^ADDR_W 32-bit words, byte range 0 .. 4·2^ADDR_W − 1.
- WAIT, 1: wait states inserted before ack. Legal range 0..7.
- MMIO_BASE, 32'hF000_0000: MMIO base address. MMIO_BASE is the cycle counter (read-only); MMIO_BASE+4 is the LED register (read/write).

- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- req  in  1  request strobe; sampled only in IDLE.
- we  in  1  1 = store, 0 = load.
- funct3  in  3  access size/extension, using RISC-V load/store encoding.
- addr  in  32  byte address (the datapath's ALU_out).
- wdata  in  32  store data (the datapath's Data_out); the low byte or low half is used for SB/SH.
- ack  out  1  one-cycle completion pulse.
- fault  out  1  valid with ack; 1 = request rejected.
- rdata  out  32  load result, valid with ack; 0 on stores and on faults.
- led_out  out  32  LED register contents.

## Operation
- FSM states: IDLE, WAIT, RESP.
- **IDLE:** on req=1, latch addr, we, funct3 and wdata, and decode the request.
  - If WAIT=0, go to RESP.
  - Otherwise load wait_cnt=WAIT−1 and go to WAIT.
- **WAIT:** decrement wait_cnt. When wait_cnt=0, go to RESP.
- **RESP:** ack=1 for exactly one cycle, then return to IDLE.
  - A req high during RESP is ignored.
  - A req still high in the following IDLE cycle starts a new request.
- **Decode, fault conditions.** Any of the following sets fault=1:
  - funct3 not in {000,001,010,100,101} for loads.
  - funct3 not in {000,001,010} for stores.
  - Halfword access with addr[0]≠0.
  - Word access with addr[1:0]≠0.
  - Address neither in RAM range nor equal to MMIO_BASE / MMIO_BASE+4.
  - Non-word access to an MMIO address.
- **Faulted request:** no state is modified, and rdata=0.
- **RAM loads:** select the byte or half from the word at addr[ADDR_W+1:2].
  - LB/LH sign-extend.
  - LBU/LHU zero-extend.
  - LW passes the word unchanged.
- **RAM stores:** use byte enables.
  - SB writes lane addr[1:0].
  - SH writes lanes {addr[1],0} and {addr[1],1}.
  - SW writes all four lanes.
- **Cycle counter:** 32-bit, increments every clk, wraps 0xFFFF_FFFF→0.
  - Loads return the value latched at the RESP entry edge.
  - Stores are ignored, with fault=0.
- **LED register:** SW writes it; LW returns it.
- RAM contents are not cleared by reset; their power-up value is undefined.

## Timing
- The req cycle is cycle 0; ack asserts in cycle WAIT+1.
  - WAIT=0: ack in cycle 1.
  - WAIT=7: ack in cycle 8.
- Store commit happens on the clock edge entering RESP. A load issued next observes the new data.
- rdata and fault are registered on the edge entering RESP and are valid only while ack=1.
- Reset values: state=IDLE, ack=0, fault=0, rdata=0, led_out=0, cycle counter=0, wait_cnt=0.
- **Reset mid-operation:** asserting rst in WAIT or RESP aborts the request.
  - A pending store is discarded if rst asserts before its commit edge.
  - No ack is produced after reset.
- **Back-to-back:** the minimum request spacing is WAIT+2 cycles, since the IDLE cycle is mandatory between requests.
- **Address edges:**
  - The last RAM byte, 4·2^ADDR_W−1, is legal for SB/LB.
  - The address 4·2^ADDR_W faults.

## Test plan
- Reset with WAIT=1, then SW 0x8000_00FF to addr 0x10, then LW 0x10 → ack in cycle 2 of each access, rdata=0x8000_00FF, fault=0.
- SB 0xAB to 0x13, then LB 0x13 → rdata=0xFFFF_FFAB; LBU 0x13 → 0x0000_00AB; LW 0x10 → 0xAB00_00FF.
- LH at 0x11, SW at 0x12, LW at 0x1000 (ADDR_W=10), and funct3=011 → each gives ack with fault=1 and rdata=0; a following LW 0x10 shows memory unchanged.
- SW 0x5A5A_5A5A to MMIO_BASE+4 → led_out=0x5A5A_5A5A one cycle after RESP entry. LW MMIO_BASE twice, 10 cycles apart → values differ by 10. SB to MMIO_BASE+4 → fault=1 and led_out unchanged.
- WAIT=0, req held high continuously → ack every 2nd cycle. WAIT=7 → ack in cycle 8.
- SW to 0x20 with rst asserted during WAIT → ack stays 0, state returns to IDLE, led_out=0. A subsequent LW 0x20 returns the pre-store contents.
